regfile_port_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer that shares the 4-entry x 16-bit register file among NREQ requesters.
- Each requester issues single read or write operations over a req/ack handshake.
- The arbiter drives the register file's read-address, write-enable and write-data pins, then returns the read data with ack.
- Sits between the core/debug/load masters and the register file; it is the only block that drives the register file pins.

---
 rtl/regfile_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter that shares a 4 x DW register file among NREQ requesters.
// Optional macro RF_ARB_LOCK_EN adds a per-requester lock input that re-grants the last winner.
module regfile_port_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 16
) (
    input  logic              clk,
    input  logic              reset,
`ifdef RF_ARB_LOCK_EN
    input  logic [NREQ-1:0]   lock,
`endif
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [2*NREQ-1:0] req_addr_a,
    input  logic [2*NREQ-1:0] req_addr_b,
    input  logic [DW*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rdata_a,
    output logic [DW-1:0]     rdata_b,
    output logic              busy,
    output logic [1:0]        rf_reg1,
    output logic [1:0]        rf_reg2,
    output logic              rf_write,
    output logic [DW-1:0]     rf_write_data,
    input  logic [DW-1:0]     rf_data1,
    input  logic [DW-1:0]     rf_data2
);

    localparam int IW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   pick;
    logic            found;
    logic            sel_we;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic [DW-1:0]   sel_wd;
    logic [IW-1:0]   ptr_nx;
    logic            win_lock;

    // Search order starts at ptr and wraps; first requesting index wins
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + i) % NREQ))) begin
                    found = 1'b1;
                    pick  = IW'(j);
                end
            end
        end
    end

    // Select the picked requester's operation fields
    always_comb begin
        sel_we = 1'b0;
        sel_a  = '0;
        sel_b  = '0;
        sel_wd = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (IW'(j) == pick) begin
                sel_we = req_we[j];
                sel_a  = req_addr_a[2*j +: 2];
                sel_b  = req_addr_b[2*j +: 2];
                sel_wd = req_wdata[DW*j +: DW];
            end
        end
    end

    // Lock of the current winner only; other requesters' lock bits are ignored
    always_comb begin
        win_lock = 1'b0;
`ifdef RF_ARB_LOCK_EN
        for (int j = 0; j < NREQ; j++) begin
            if (IW'(j) == winner) begin
                win_lock = lock[j];
            end
        end
`endif
    end

    // Rotation pointer moves past the winner unless the winner holds a lock
    always_comb begin
        ptr_nx = '0;
        if (win_lock) begin
            ptr_nx = winner;
        end else if (int'(winner) == NREQ - 1) begin
            ptr_nx = '0;
        end else begin
            ptr_nx = winner + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> RESP -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? ISSUE : IDLE;
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant capture, register-file pin drive and pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr           <= '0;
            winner        <= '0;
            rf_reg1       <= '0;
            rf_reg2       <= '0;
            rf_write      <= 1'b0;
            rf_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner        <= pick;
                        rf_reg1       <= sel_a;
                        rf_reg2       <= sel_b;
                        rf_write_data <= sel_wd;
                        rf_write      <= sel_we;
                    end
                end
                ISSUE: begin
                    rf_write <= 1'b0;
                end
                RESP: begin
                    ptr <= ptr_nx;
                end
                default: begin
                    rf_write <= 1'b0;
                end
            endcase
        end
    end

    // One-hot completion pulse during RESP
    always_comb begin
        ack = '0;
        if (state == RESP) begin
            for (int j = 0; j < NREQ; j++) begin
                if (IW'(j) == winner) begin
                    ack[j] = 1'b1;
                end
            end
        end
    end

    assign busy    = (state != IDLE);
    assign rdata_a = rf_data1;
    assign rdata_b = rf_data2;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed testbench for regfile_port_arbiter with a behavioural register file.
// Define RF_ARB_LOCK_EN to also exercise the lock feature.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  lock;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [3:0]  req_addr_a;
    logic [3:0]  req_addr_b;
    logic [31:0] req_wdata;
    logic [1:0]  ack;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic        busy;
    logic [1:0]  rf_reg1;
    logic [1:0]  rf_reg2;
    logic        rf_write;
    logic [15:0] rf_write_data;
    logic [15:0] rf_data1;
    logic [15:0] rf_data2;

    int tests = 0;
    int fails = 0;

    logic [15:0] regs [4];

    regfile_port_arbiter #(.NREQ(2), .DW(16)) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef RF_ARB_LOCK_EN
        .lock          (lock),
`endif
        .req           (req),
        .req_we        (req_we),
        .req_addr_a    (req_addr_a),
        .req_addr_b    (req_addr_b),
        .req_wdata     (req_wdata),
        .ack           (ack),
        .rdata_a       (rdata_a),
        .rdata_b       (rdata_b),
        .busy          (busy),
        .rf_reg1       (rf_reg1),
        .rf_reg2       (rf_reg2),
        .rf_write      (rf_write),
        .rf_write_data (rf_write_data),
        .rf_data1      (rf_data1),
        .rf_data2      (rf_data2)
    );

    always #5 clk = ~clk;

    // Register file: write on negedge, read ports registered on posedge
    always @(negedge clk) begin
        if (rf_write) regs[rf_reg1] <= rf_write_data;
    end

    always @(posedge clk) begin
        rf_data1 <= regs[rf_reg1];
        rf_data2 <= regs[rf_reg2];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic we, input logic [1:0] a,
                           input logic [1:0] b, input logic [15:0] wd);
        req[idx]            = 1'b1;
        req_we[idx]         = we;
        req_addr_a[2*idx +: 2] = a;
        req_addr_b[2*idx +: 2] = b;
        req_wdata[16*idx +: 16] = wd;
    endtask

    task automatic clear_req;
        req = '0;
    endtask

    task automatic pulse_reset;
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_write(input int idx, input logic [1:0] a, input logic [15:0] wd);
        set_req(idx, 1'b1, a, a, wd);
        tick();
        clear_req();
        tick();
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (ack !== 2'b00) begin fails++; $display("FAIL reset_ack: got %b want 00", ack); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++;
        if (rf_write !== 1'b0) begin fails++; $display("FAIL reset_rf_write: got %b want 0", rf_write); end
        tests++;
        if (rf_reg1 !== 2'd0 || rf_reg2 !== 2'd0) begin
            fails++; $display("FAIL reset_rf_reg: got %0d/%0d want 0/0", rf_reg1, rf_reg2);
        end
        tests++;
        if (rf_write_data !== 16'h0) begin
            fails++; $display("FAIL reset_wdata: got %h want 0000", rf_write_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write;
        set_req(0, 1'b1, 2'd2, 2'd2, 16'hBEEF);
        tick();
        clear_req();
        tests++;
        if (busy !== 1'b1 || ack !== 2'b00) begin
            fails++; $display("FAIL write_issue: got busy=%b ack=%b want 1/00", busy, ack);
        end
        tests++;
        if (rf_write !== 1'b1 || rf_reg1 !== 2'd2 || rf_write_data !== 16'hBEEF) begin
            fails++;
            $display("FAIL write_pins: got we=%b r1=%0d wd=%h want 1/2/beef", rf_write, rf_reg1, rf_write_data);
        end
        tick();
        tests++;
        if (ack !== 2'b01) begin fails++; $display("FAIL write_ack: got %b want 01", ack); end
        tests++;
        if (rf_write !== 1'b0) begin fails++; $display("FAIL write_we_len: got %b want 0", rf_write); end
        tests++;
        if (rdata_a !== 16'hBEEF) begin fails++; $display("FAIL write_rdata_a: got %h want beef", rdata_a); end
        tick();
        tests++;
        if (ack !== 2'b00 || busy !== 1'b0) begin
            fails++; $display("FAIL write_done: got ack=%b busy=%b want 00/0", ack, busy);
        end
    endtask

    task automatic test_read;
        do_write(0, 2'd1, 16'h0011);
        do_write(0, 2'd3, 16'h3300);
        set_req(1, 1'b0, 2'd1, 2'd3, 16'h0);
        tick();
        clear_req();
        tests++;
        if (rf_write !== 1'b0 || ack !== 2'b00) begin
            fails++; $display("FAIL read_issue: got we=%b ack=%b want 0/00", rf_write, ack);
        end
        tick();
        tests++;
        if (ack !== 2'b10) begin fails++; $display("FAIL read_ack: got %b want 10", ack); end
        tests++;
        if (rdata_a !== 16'h0011 || rdata_b !== 16'h3300) begin
            fails++; $display("FAIL read_data: got %h/%h want 0011/3300", rdata_a, rdata_b);
        end
        tests++;
        if (rf_write !== 1'b0) begin fails++; $display("FAIL read_we: got %b want 0", rf_write); end
        tick();
    endtask

    task automatic test_same_addr;
        set_req(0, 1'b1, 2'd0, 2'd0, 16'h1234);
        tick();
        clear_req();
        tick();
        tests++;
        if (ack !== 2'b01) begin fails++; $display("FAIL same_ack: got %b want 01", ack); end
        tests++;
        if (rdata_a !== 16'h1234 || rdata_b !== 16'h1234) begin
            fails++; $display("FAIL same_data: got %h/%h want 1234/1234", rdata_a, rdata_b);
        end
        tick();
    endtask

    task automatic test_reset_issue;
        do_write(0, 2'd2, 16'hBEEF);
        set_req(0, 1'b1, 2'd3, 2'd3, 16'hDEAD);
        tick();
        clear_req();
        #1 reset = 1'b1;
        #1;
        tests++;
        if (rf_write !== 1'b0 || busy !== 1'b0 || ack !== 2'b00) begin
            fails++;
            $display("FAIL rst_issue: got we=%b busy=%b ack=%b want 0/0/00", rf_write, busy, ack);
        end
        tick();
        reset = 1'b0;
        tests++;
        if (ack !== 2'b00 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_no_ack: got ack=%b busy=%b want 00/0", ack, busy);
        end
        set_req(0, 1'b0, 2'd3, 2'd1, 16'h0);
        set_req(1, 1'b0, 2'd2, 2'd2, 16'h0);
        tick();
        clear_req();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rst_regrant: got busy=%b want 1", busy); end
        tick();
        tests++;
        if (ack !== 2'b01) begin fails++; $display("FAIL rst_ptr: got %b want 01", ack); end
        tests++;
        if (rdata_a !== 16'h3300 || rdata_b !== 16'h0011) begin
            fails++; $display("FAIL rst_data: got %h/%h want 3300/0011", rdata_a, rdata_b);
        end
        tick();
    endtask

    task automatic test_rotation;
        logic [1:0]  exp_ack;
        logic [15:0] exp_a;
        pulse_reset();
        set_req(0, 1'b0, 2'd2, 2'd0, 16'h0);
        set_req(1, 1'b0, 2'd1, 2'd3, 16'h0);
        for (int k = 0; k < 4; k++) begin
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a   = (k % 2 == 0) ? 16'hBEEF : 16'h0011;
            tick();
            tests++;
            if (busy !== 1'b1 || ack !== 2'b00) begin
                fails++; $display("FAIL rot_issue%0d: got busy=%b ack=%b want 1/00", k, busy, ack);
            end
            tick();
            tests++;
            if (ack !== exp_ack || rdata_a !== exp_a) begin
                fails++;
                $display("FAIL rot_ack%0d: got ack=%b rd=%h want %b/%h", k, ack, rdata_a, exp_ack, exp_a);
            end
            tick();
            tests++;
            if (busy !== 1'b0 || ack !== 2'b00) begin
                fails++; $display("FAIL rot_idle%0d: got busy=%b ack=%b want 0/00", k, busy, ack);
            end
        end
        clear_req();
        tick();
    endtask

`ifdef RF_ARB_LOCK_EN
    task automatic test_lock;
        pulse_reset();
        lock = 2'b01;
        set_req(0, 1'b0, 2'd1, 2'd1, 16'h0);
        set_req(1, 1'b0, 2'd3, 2'd3, 16'h0);
        tick();
        tick();
        tests++;
        if (ack !== 2'b01) begin fails++; $display("FAIL lock_op1: got %b want 01", ack); end
        tick();
        tick();
        lock = 2'b00;
        tick();
        tests++;
        if (ack !== 2'b01) begin fails++; $display("FAIL lock_op2: got %b want 01", ack); end
        tick();
        tick();
        tick();
        tests++;
        if (ack !== 2'b10) begin fails++; $display("FAIL lock_op3: got %b want 10", ack); end
        clear_req();
        tick();
    endtask
`endif

    initial begin
        reset      = 1'b1;
        lock       = '0;
        req        = '0;
        req_we     = '0;
        req_addr_a = '0;
        req_addr_b = '0;
        req_wdata  = '0;
        for (int i = 0; i < 4; i++) regs[i] = 16'h0;
        test_reset();
        test_write();
        test_read();
        test_same_addr();
        test_reset_issue();
        test_rotation();
`ifdef RF_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
